// File: rtl/opsg_pkg.sv
// opsg_pkg: constants shared by the PSG blocks and the I2S transmitter.
//   SAMPLE_W           - bits per audio channel
//   I2S_SLOTS          - BCLK slots per I2S frame (both channels)
//   I2S_LEFT_LAST_SLOT - last slot of the frame with lrclk low
//   SLOT_W             - width of a slot index
package opsg_pkg;

  localparam int SAMPLE_W           = 16;
  localparam int I2S_SLOTS          = 32;
  localparam int I2S_LEFT_LAST_SLOT = 15;
  localparam int SLOT_W             = $clog2(I2S_SLOTS);

endpackage

// File: rtl/opsg_bclk_gen.sv
// opsg_bclk_gen: divides the system clock down to the I2S bit clock.
// Ports:
//   clk      - system clock
//   n_rst    - asynchronous active-low reset
//   bclk     - registered bit clock, period 2*BCLK_DIV clk
//   fall_evt - high in the clk cycle whose closing edge drives bclk 1->0;
//              registers enabled by it update on the same edge as bclk falls
module opsg_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic n_rst,
  output logic bclk,
  output logic fall_evt
);

  // A divide-by-1 still needs a one-bit counter so the code stays uniform.
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap     = (div_cnt == DIV_LAST);
  assign fall_evt = wrap & bclk;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/opsg_i2s_tx.sv
// opsg_i2s_tx: serialises the PSG stereo mix into a Philips I2S stream.
// Ports:
//   clk, n_rst              - system clock, asynchronous active-low reset
//   audio_left, audio_right - 16-bit two's complement samples from opsg
//   mute                    - forces both captured samples to zero
//   bclk, lrclk, sdata      - registered I2S outputs (lrclk 0 = left)
//   sample_tick             - one-clk pulse in the cycle a frame is captured
// Samples are captured once per frame on the bclk fall that enters slot 0.
// Data is delayed by one slot: slot 0 carries the previous frame's right
// LSB, slots 1..16 the left word, slots 17..31 right bits 15..1.
module opsg_i2s_tx
  import opsg_pkg::*;
#(
  parameter int BCLK_DIV = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [SAMPLE_W-1:0] audio_left,
  input  logic [SAMPLE_W-1:0] audio_right,
  input  logic                mute,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                sample_tick
);

  if (SAMPLE_W != opsg_pkg::SAMPLE_W) begin : g_bad_sample_w
    $error("opsg_i2s_tx supports only the package sample width");
  end

  localparam int MSB = SAMPLE_W - 1;
  localparam logic [SLOT_W-1:0] LEFT_LAST = SLOT_W'(I2S_LEFT_LAST_SLOT);
  localparam logic [SLOT_W-1:0] LEFT_END  = SLOT_W'(I2S_LEFT_LAST_SLOT + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(I2S_SLOTS - 1);

  logic                fall_evt;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   slot_nxt;
  logic [SAMPLE_W-1:0] sh_l;
  logic [SAMPLE_W-1:0] sh_r;
  logic                r_lsb;   // right bit 0, carried into the next frame's slot 0

  opsg_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .n_rst    (n_rst),
    .bclk     (bclk),
    .fall_evt (fall_evt)
  );

  // Slot counter wraps 31 -> 0 naturally in SLOT_W bits.
  assign slot_nxt = slot + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      slot        <= SLOT_LAST;   // first fall after reset enters slot 0
      sh_l        <= '0;
      sh_r        <= '0;
      r_lsb       <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      if (fall_evt) begin
        slot  <= slot_nxt;
        lrclk <= (slot_nxt > LEFT_LAST);
        if (slot_nxt == '0) begin
          sdata       <= r_lsb;
          sh_l        <= mute ? '0 : audio_left;
          sh_r        <= mute ? '0 : audio_right;
          sample_tick <= 1'b1;
        end else if (slot_nxt <= LEFT_END) begin
          sdata <= sh_l[MSB];
          sh_l  <= {sh_l[MSB-1:0], 1'b0};
        end else begin
          sdata <= sh_r[MSB];
          sh_r  <= {sh_r[MSB-1:0], 1'b0};
          // After 14 shifts bit 14 holds the original LSB; park it for slot 0.
          if (slot_nxt == SLOT_LAST) begin
            r_lsb <= sh_r[MSB-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_opsg_i2s_tx.sv
// tb_opsg_i2s_tx: directed bench for opsg_i2s_tx. Two instances share the
// stimulus: BCLK_DIV=2 and BCLK_DIV=1; sel_div1 picks the one observed.
module tb_opsg_i2s_tx;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [15:0] audio_left = '0;
  logic [15:0] audio_right = '0;
  logic        mute = 1'b0;

  logic bclk2, lrclk2, sdata2, tick2;
  logic bclk1, lrclk1, sdata1, tick1;
  logic sel_div1 = 1'b0;
  logic m_bclk, m_lrclk, m_sdata, m_tick;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_total = 0;

  localparam logic [32:0] EXP_LR = 33'h0_FFFF_0000;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  opsg_i2s_tx #(.BCLK_DIV(2), .SAMPLE_W(16)) dut2 (
    .clk(clk), .n_rst(n_rst), .audio_left(audio_left), .audio_right(audio_right),
    .mute(mute), .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2), .sample_tick(tick2)
  );

  opsg_i2s_tx #(.BCLK_DIV(1), .SAMPLE_W(16)) dut1 (
    .clk(clk), .n_rst(n_rst), .audio_left(audio_left), .audio_right(audio_right),
    .mute(mute), .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1), .sample_tick(tick1)
  );

  assign m_bclk  = sel_div1 ? bclk1  : bclk2;
  assign m_lrclk = sel_div1 ? lrclk1 : lrclk2;
  assign m_sdata = sel_div1 ? sdata1 : sdata2;
  assign m_tick  = sel_div1 ? tick1  : tick2;

  always @(negedge clk) if (m_tick) tick_total++;

  // ---------------- driver tasks ----------------
  // Holds reset for two edges and releases on a falling clk edge, so the
  // next rising edge is edge 1 after release.
  task automatic reset_dut();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Returns number of rising edges until sample_tick is seen (-1 on timeout).
  // Leaves time at #1 after the capture edge.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (m_tick) begin
        n = i;
        break;
      end
    end
  endtask

  // Starting #1 after a capture edge: samples slots 0..31 and the next
  // slot 0 (index 32). Optionally changes audio_left after slot chg_slot.
  task automatic grab_frame(input int div, input int chg_slot, input logic [15:0] chg_val,
                            output logic [32:0] sd, output logic [32:0] lr, output int ticks);
    int t0;
    t0 = tick_total;
    for (int s = 0; s <= 32; s++) begin
      if (s > 0) begin
        repeat (2 * div) @(posedge clk);
        #1;
      end
      sd[s] = m_sdata;
      lr[s] = m_lrclk;
      if (s == chg_slot) audio_left = chg_val;
    end
    ticks = tick_total - t0;
  endtask

  // Expected sdata per slot: previous right LSB, left 15..0, right 15..1, right LSB.
  function automatic logic [32:0] exp_sd(input logic [15:0] l, input logic [15:0] r, input logic p);
    logic [32:0] v;
    v[0] = p;
    for (int i = 0; i < 16; i++) v[1 + i] = l[15 - i];
    for (int i = 0; i < 15; i++) v[17 + i] = r[15 - i];
    v[32] = r[0];
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic exp_b;
    sel_div1 = 1'b0;
    audio_left = 16'h0000;
    audio_right = 16'h8000;
    reset_dut();
    wait_tick(n);
    repeat (4 * 17 + 2) @(posedge clk); // slot 17, bclk high, right MSB = 1
    #1;
    tests_run++;
    if ({m_bclk, m_lrclk, m_sdata} !== 3'b111) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got %b expected 111", {m_bclk, m_lrclk, m_sdata});
    end
    n_rst = 1'b0;
    #1;
    tests_run++;
    if ({m_bclk, m_lrclk, m_sdata, m_tick} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %b expected 0000", {m_bclk, m_lrclk, m_sdata, m_tick});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({m_bclk, m_lrclk, m_sdata, m_tick} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_held_outputs: got %b expected 0000", {m_bclk, m_lrclk, m_sdata, m_tick});
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      exp_b = (k == 2 || k == 3 || k == 6);
      tests_run++;
      if (m_bclk !== exp_b || m_tick !== (k == 4)) begin
        tests_failed++;
        $display("FAIL reset_release_edge%0d: bclk=%b tick=%b expected bclk=%b tick=%b",
                 k, m_bclk, m_tick, exp_b, (k == 4));
      end
    end
  endtask

  task automatic test_serial_format();
    int n, ticks;
    logic [32:0] sd, lr;
    sel_div1 = 1'b0;
    audio_left = 16'hA55A;
    audio_right = 16'h0F0F;
    reset_dut();
    wait_tick(n);
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL first_capture_edge: got %0d expected 4", n);
    end
    grab_frame(2, -1, 16'h0, sd, lr, ticks);
    tests_run++;
    if (sd !== exp_sd(16'hA55A, 16'h0F0F, 1'b0)) begin
      tests_failed++;
      $display("FAIL serial_sdata: got %h expected %h", sd, exp_sd(16'hA55A, 16'h0F0F, 1'b0));
    end
    tests_run++;
    if (lr !== EXP_LR) begin
      tests_failed++;
      $display("FAIL serial_lrclk: got %h expected %h", lr, EXP_LR);
    end
    wait_tick(n);
    tests_run++;
    if (n != 128) begin
      tests_failed++;
      $display("FAIL frame_length_div2: got %0d expected 128", n);
    end
  endtask

  task automatic test_capture_isolation();
    int n, ticks;
    logic [32:0] sd, lr;
    sel_div1 = 1'b0;
    audio_left = 16'h1234;
    audio_right = 16'h0001;
    reset_dut();
    wait_tick(n);
    grab_frame(2, 8, 16'hFFFF, sd, lr, ticks);
    tests_run++;
    if (sd !== exp_sd(16'h1234, 16'h0001, 1'b0)) begin
      tests_failed++;
      $display("FAIL isolation_current: got %h expected %h", sd, exp_sd(16'h1234, 16'h0001, 1'b0));
    end
    tests_run++;
    if (ticks != 1) begin
      tests_failed++;
      $display("FAIL isolation_ticks1: got %0d expected 1", ticks);
    end
    grab_frame(2, -1, 16'h0, sd, lr, ticks);
    tests_run++;
    if (sd !== exp_sd(16'hFFFF, 16'h0001, 1'b1)) begin
      tests_failed++;
      $display("FAIL isolation_next: got %h expected %h", sd, exp_sd(16'hFFFF, 16'h0001, 1'b1));
    end
    tests_run++;
    if (ticks != 1) begin
      tests_failed++;
      $display("FAIL isolation_ticks2: got %0d expected 1", ticks);
    end
  endtask

  task automatic test_mute();
    int n, ticks;
    logic [32:0] sd, lr;
    sel_div1 = 1'b0;
    audio_left = 16'h7FFF;
    audio_right = 16'h7FFF;
    mute = 1'b1;
    reset_dut();
    wait_tick(n);
    mute = 1'b0;
    grab_frame(2, -1, 16'h0, sd, lr, ticks);
    tests_run++;
    if (sd !== 33'h0) begin
      tests_failed++;
      $display("FAIL mute_frame: got %h expected %h", sd, 33'h0);
    end
    grab_frame(2, -1, 16'h0, sd, lr, ticks);
    tests_run++;
    if (sd !== exp_sd(16'h7FFF, 16'h7FFF, 1'b0)) begin
      tests_failed++;
      $display("FAIL unmute_frame: got %h expected %h", sd, exp_sd(16'h7FFF, 16'h7FFF, 1'b0));
    end
  endtask

  task automatic test_min_divider();
    int n, ticks;
    logic [32:0] sd, lr;
    logic prev;
    sel_div1 = 1'b1;
    audio_left = 16'h8001;
    audio_right = 16'h8000;
    reset_dut();
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (m_bclk !== k[0] || m_tick !== (k == 2)) begin
        tests_failed++;
        $display("FAIL div1_release_edge%0d: bclk=%b tick=%b expected bclk=%b tick=%b",
                 k, m_bclk, m_tick, k[0], (k == 2));
      end
    end
    grab_frame(1, -1, 16'h0, sd, lr, ticks);
    tests_run++;
    if (sd !== exp_sd(16'h8001, 16'h8000, 1'b0)) begin
      tests_failed++;
      $display("FAIL div1_frame1: got %h expected %h", sd, exp_sd(16'h8001, 16'h8000, 1'b0));
    end
    tests_run++;
    if (lr !== EXP_LR) begin
      tests_failed++;
      $display("FAIL div1_lrclk: got %h expected %h", lr, EXP_LR);
    end
    grab_frame(1, -1, 16'h0, sd, lr, ticks);
    tests_run++;
    if (sd !== exp_sd(16'h8001, 16'h8000, 1'b0)) begin
      tests_failed++;
      $display("FAIL div1_frame2: got %h expected %h", sd, exp_sd(16'h8001, 16'h8000, 1'b0));
    end
    wait_tick(n);
    tests_run++;
    if (n != 64) begin
      tests_failed++;
      $display("FAIL frame_length_div1: got %0d expected 64", n);
    end
    prev = m_bclk;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (m_bclk !== ~prev) begin
        tests_failed++;
        $display("FAIL div1_bclk_toggle%0d: got %b expected %b", k, m_bclk, ~prev);
      end
      prev = m_bclk;
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, ticks;
    logic [32:0] sd, lr;
    sel_div1 = 1'b0;
    audio_left = 16'hAAAA;
    audio_right = 16'h5555;
    reset_dut();
    wait_tick(n);
    repeat (4 * 20) @(posedge clk); // entering slot 20: right bit 12 = 1
    #1;
    tests_run++;
    if ({m_lrclk, m_sdata} !== 2'b11) begin
      tests_failed++;
      $display("FAIL slot20_state: got %b expected 11", {m_lrclk, m_sdata});
    end
    n_rst = 1'b0;
    #1;
    tests_run++;
    if ({m_bclk, m_lrclk, m_sdata, m_tick} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midframe_reset_outputs: got %b expected 0000", {m_bclk, m_lrclk, m_sdata, m_tick});
    end
    audio_left = 16'hC3C3;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    wait_tick(n);
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL midframe_restart_edge: got %0d expected 4", n);
    end
    grab_frame(2, -1, 16'h0, sd, lr, ticks);
    tests_run++;
    if (sd !== exp_sd(16'hC3C3, 16'h5555, 1'b0)) begin
      tests_failed++;
      $display("FAIL midframe_restart_frame: got %h expected %h", sd, exp_sd(16'hC3C3, 16'h5555, 1'b0));
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_serial_format();
    test_capture_isolation();
    test_mute();
    test_min_divider();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
